stdcell_test_sequencer: RTL and testbench

Wishbone-programmable sequencer for exhaustive on-chip functional testing of the user-area standard-cell instances.
- Selects one cell-under-test (CUT) and drives every input combination onto its stimulus lines.
- Waits a programmed settle time, then samples the CUT output through a synchroniser and compares it with a software-loaded truth table.
- Reports pass/fail, mismatch count and first failing vector.
- Sits between the Wishbone slave port and the cell-instance array, replacing direct pad drive of the cell inputs.

---
 rtl/stdcell_seq_pkg.sv | 37 +++
 rtl/stdcell_seq_sync.sv | 22 ++
 rtl/stdcell_test_sequencer.sv | 256 +++++++++++++++++++++++++
 tb/tb_stdcell_test_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stdcell_seq_pkg.sv
// Shared definitions for the standard-cell test sequencer: FSM states,
// register offsets, CTRL/STATUS field positions and the ERRCNT saturation value.
package stdcell_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_SAMPLE = 2'd3
    } seq_state_t;

    // Byte offsets inside the 16-byte window
    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_TRUTH  = 4'h4;
    localparam logic [3:0] REG_SETTLE = 4'h8;
    localparam logic [3:0] REG_STATUS = 4'hC;

    // CTRL fields
    localparam int CTRL_START   = 0;
    localparam int CTRL_ABORT   = 1;
    localparam int CTRL_SEL_LSB = 8;
    localparam int CTRL_SEL_MSB = 12;
    localparam int CTRL_NUM_LSB = 16;
    localparam int CTRL_NUM_MSB = 18;

    // STATUS fields
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_PASS    = 2;
    localparam int STAT_IRQ     = 3;
    localparam int STAT_FF_LSB  = 4;
    localparam int STAT_ERR_LSB = 16;

    // All-ones pattern; the counter compares against its low ERR_W bits
    localparam logic [15:0] ERRCNT_SAT = 16'hFFFF;

endpackage

// File: rtl/stdcell_seq_sync.sv
// Two-flop synchroniser for the asynchronous CUT output bit.
module stdcell_seq_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;

    // Shift the raw bit through two flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/stdcell_test_sequencer.sv
// Wishbone-programmable exhaustive tester for one standard cell at a time.
// Drives every input vector onto stim_o, waits SETTLE+2 cycles, samples the
// selected (synchronised) cell output and checks it against TRUTH.
// Optional macro STDCELL_SEQ_IRQ_EN enables the completion interrupt irq_o
// (mirrored in STATUS[3]); without it irq_o is tied low.
module stdcell_test_sequencer
    import stdcell_seq_pkg::*;
#(
    parameter int          NCELLS    = 19,
    parameter int          NIN       = 4,
    parameter int          ERR_W     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic [NIN-1:0]    stim_o,
    output logic [4:0]        cell_sel_o,
    input  logic [NCELLS-1:0] cell_y_i,
    output logic              irq_o
);

    localparam int NVEC = 2 ** NIN;

    // Bus handshake: a cycle is accepted when stb&cyc hit the window and no
    // ack is currently out; the ack (with registered read data) follows one
    // cycle later and lasts exactly one cycle. A hit held through the ack
    // cycle is not accepted again until ack drops.
    logic        hit, accept, wr_en;
    logic [1:0]  word;
    logic        ack_q;
    logic [31:0] dat_q, rd_mux, sel_mask;
    logic        wr_ctrl, wr_truth, wr_settle, wr_status;
    logic        start_req, abort_req, busy;

    logic [4:0]      cell_sel_q;
    logic [2:0]      num_in_q;
    logic [NVEC-1:0] truth_q;
    logic [7:0]      settle_q;

    seq_state_t     state_q, state_d;
    logic [NIN-1:0] vec_q, last_vec, stim_q, first_fail_q;
    logic [8:0]     cnt_q;
    logic [ERR_W-1:0] errcnt_q;
    logic           done_q, pass_q, irq_q;
    logic           start_run, finish;
    logic [2:0]     n_eff;
    logic [31:0]    span, y_ext;
    logic           cell_bit, y_sync, mismatch;

    assign hit       = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign accept    = hit & ~ack_q;
    assign wr_en     = accept & wbs_we_i;
    assign word      = wbs_adr_i[3:2];
    assign wr_ctrl   = wr_en & (word == REG_CTRL[3:2]);
    assign wr_truth  = wr_en & (word == REG_TRUTH[3:2]);
    assign wr_settle = wr_en & (word == REG_SETTLE[3:2]);
    assign wr_status = wr_en & (word == REG_STATUS[3:2]);
    assign sel_mask  = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign start_req = wr_ctrl & wbs_sel_i[0] & wbs_dat_i[CTRL_START];
    assign abort_req = wr_ctrl & wbs_sel_i[0] & wbs_dat_i[CTRL_ABORT];
    assign busy      = (state_q != ST_IDLE);

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_q;
    assign stim_o     = stim_q;
    assign cell_sel_o = cell_sel_q;

    // Effective input count: 0 means 1, anything above NIN means NIN
    always_comb begin
        n_eff = num_in_q;
        if (num_in_q == 3'd0)
            n_eff = 3'd1;
        else if (int'(num_in_q) > NIN)
            n_eff = 3'(NIN);
    end
    assign span     = 32'd1 << n_eff;
    assign last_vec = NIN'(span - 32'd1);

    // Out-of-range CELL_SEL lands on the zero-extended upper bits
    assign y_ext    = 32'(cell_y_i);
    assign cell_bit = y_ext[cell_sel_q];

    stdcell_seq_sync u_sync (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .d     (cell_bit),
        .q     (y_sync)
    );

    assign mismatch = y_sync ^ truth_q[vec_q];

    // Read-data mux for the addressed register
    always_comb begin
        rd_mux = '0;
        case (word)
            REG_CTRL[3:2]: begin
                rd_mux[CTRL_SEL_MSB:CTRL_SEL_LSB] = cell_sel_q;
                rd_mux[CTRL_NUM_MSB:CTRL_NUM_LSB] = num_in_q;
            end
            REG_TRUTH[3:2]:  rd_mux[NVEC-1:0] = truth_q;
            REG_SETTLE[3:2]: rd_mux[7:0]      = settle_q;
            default: begin
                rd_mux[STAT_BUSY]                 = busy;
                rd_mux[STAT_DONE]                 = done_q;
                rd_mux[STAT_PASS]                 = pass_q;
                rd_mux[STAT_IRQ]                  = irq_q;
                rd_mux[STAT_FF_LSB +: NIN]        = first_fail_q;
                rd_mux[STAT_ERR_LSB +: ERR_W]     = errcnt_q;
            end
        endcase
    end

    // Ack pulse and registered read data
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= accept;
            dat_q <= (accept & ~wbs_we_i) ? rd_mux : 32'h0;
        end
    end

    // Configuration registers, frozen while a run is in progress
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cell_sel_q <= '0;
            num_in_q   <= '0;
            truth_q    <= '0;
            settle_q   <= '0;
        end else if (!busy) begin
            if (wr_ctrl && wbs_sel_i[1])
                cell_sel_q <= wbs_dat_i[CTRL_SEL_MSB:CTRL_SEL_LSB];
            if (wr_ctrl && wbs_sel_i[2])
                num_in_q <= wbs_dat_i[CTRL_NUM_MSB:CTRL_NUM_LSB];
            if (wr_truth)
                truth_q <= (truth_q & ~sel_mask[NVEC-1:0]) | (wbs_dat_i[NVEC-1:0] & sel_mask[NVEC-1:0]);
            if (wr_settle && wbs_sel_i[0])
                settle_q <= wbs_dat_i[7:0];
        end
    end

    // FSM state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // FSM next state; ABORT overrides everything, including a START in the same write
    always_comb begin
        state_d   = state_q;
        start_run = 1'b0;
        finish    = 1'b0;
        if (abort_req) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_req) begin
                        state_d   = ST_APPLY;
                        start_run = 1'b1;
                    end
                end
                ST_APPLY:  state_d = ST_SETTLE;
                // Counter reaches zero as SAMPLE is entered: SETTLE+2 cycles here
                ST_SETTLE: if (cnt_q == 9'd1) state_d = ST_SAMPLE;
                default: begin
                    if (vec_q == last_vec) begin
                        state_d = ST_IDLE;
                        finish  = 1'b1;
                    end else begin
                        state_d = ST_APPLY;
                    end
                end
            endcase
        end
    end

    // Run datapath: vector, wait counter, stimulus and result bookkeeping
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            vec_q        <= '0;
            stim_q       <= '0;
            cnt_q        <= '0;
            errcnt_q     <= '0;
            first_fail_q <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            if (start_run) begin
                vec_q        <= '0;
                errcnt_q     <= '0;
                first_fail_q <= '0;
                done_q       <= 1'b0;
                pass_q       <= 1'b0;
            end
            if (state_q == ST_APPLY) begin
                stim_q <= vec_q;
                cnt_q  <= {1'b0, settle_q} + 9'd2;
            end
            if (state_q == ST_SETTLE)
                cnt_q <= cnt_q - 9'd1;
            if (state_q == ST_SAMPLE && !abort_req) begin
                if (mismatch) begin
                    if (errcnt_q != ERRCNT_SAT[ERR_W-1:0])
                        errcnt_q <= errcnt_q + 1'b1;
                    if (errcnt_q == '0)
                        first_fail_q <= vec_q;
                end
                if (finish) begin
                    done_q <= 1'b1;
                    pass_q <= (errcnt_q == '0) & ~mismatch;
                    stim_q <= '0;
                end else begin
                    vec_q <= vec_q + 1'b1;
                end
            end
            if (abort_req) begin
                stim_q <= '0;
                done_q <= 1'b0;
            end
        end
    end

`ifdef STDCELL_SEQ_IRQ_EN
    logic unused_bits;
    assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:19]};

    // Completion interrupt: set on finish, cleared by STATUS[1] write-1 or START
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)
            irq_q <= 1'b0;
        else if (finish)
            irq_q <= 1'b1;
        else if (start_run || (wr_status && wbs_sel_i[0] && wbs_dat_i[STAT_DONE]))
            irq_q <= 1'b0;
    end
`else
    logic unused_bits;
    assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:19], wr_status};
    assign irq_q       = 1'b0;
`endif

    assign irq_o = irq_q;

endmodule

// File: tb/tb_stdcell_test_sequencer.sv
// Directed bench for stdcell_test_sequencer. Instance A (default parameters)
// tests an AND2 cell model; instance B (ERR_W=2, second window) checks
// ERRCNT saturation. Both share one Wishbone bus.
module tb_stdcell_test_sequencer;

    localparam logic [31:0] BASE_A = 32'h3000_0000;
    localparam logic [31:0] BASE_B = 32'h3000_0010;
`ifdef STDCELL_SEQ_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif
    localparam logic [31:0] IRQB = {28'h0, IRQ_ON, 3'b000};

    // Clock and reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        stb = 1'b0, cyc_o = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack_a, ack_b, irq_a, irq_b;
    logic [31:0] dat_a, dat_b;
    logic [3:0]  stim_a, stim_b;
    logic [4:0]  csel_a, csel_b;
    logic [18:0] cell_y_a, cell_y_b;

    // Cell model: 3 = AND2, 4 = OR2, 18 = tied high, everything else low
    always_comb begin
        cell_y_a     = '0;
        cell_y_a[3]  = stim_a[0] & stim_a[1];
        cell_y_a[4]  = stim_a[0] | stim_a[1];
        cell_y_a[18] = 1'b1;
    end
    assign cell_y_b = '1;

    stdcell_test_sequencer #(.BASE_ADDR(BASE_A)) u_dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc_o), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack_a), .wbs_dat_o(dat_a),
        .stim_o(stim_a), .cell_sel_o(csel_a), .cell_y_i(cell_y_a), .irq_o(irq_a)
    );

    stdcell_test_sequencer #(.ERR_W(2), .BASE_ADDR(BASE_B)) u_dut_sat (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc_o), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack_b), .wbs_dat_o(dat_b),
        .stim_o(stim_b), .cell_sel_o(csel_b), .cell_y_i(cell_y_b), .irq_o(irq_b)
    );

    // Scoreboard counters
    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver: one Wishbone cycle, bounded wait for ack
    task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic exp_ack, output logic [31:0] rdata);
        logic got;
        got   = 1'b0;
        rdata = '0;
        @(negedge clk);
        stb = 1'b1; cyc_o = 1'b1; we = w; adr = a; wdat = d; sel = s;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (ack_a || ack_b) begin
                got   = 1'b1;
                rdata = ack_a ? dat_a : dat_b;
                break;
            end
        end
        stb = 1'b0; cyc_o = 1'b0; we = 1'b0;
        check("wb_ack", {31'h0, got}, {31'h0, exp_ack});
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb_access(1'b1, a, d, 4'hF, 1'b1, dummy);
    endtask

    task automatic wb_rd(input logic [31:0] a, output logic [31:0] d);
        wb_access(1'b0, a, 32'h0, 4'hF, 1'b1, d);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] r;
        int t0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_stim", 32'(stim_a), 32'h0);
        check("rst_cell_sel", 32'(csel_a), 32'h0);
        check("rst_ack", 32'(ack_a), 32'h0);
        check("rst_irq", 32'(irq_a), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wb_rd(BASE_A + 32'hC, r);  check("rst_status", r, 32'h0);
        wb_rd(BASE_A + 32'h0, r);  check("rst_ctrl", r, 32'h0);

        // Byte enables and address miss
        wb_wr(BASE_A + 32'h4, 32'h0000_1234);
        wb_access(1'b1, BASE_A + 32'h4, 32'h0000_FFFF, 4'b0010, 1'b1, r);
        wb_rd(BASE_A + 32'h4, r);  check("truth_sel", r, 32'h0000_FF34);
        wb_access(1'b1, 32'h3000_0100, 32'h0, 4'hF, 1'b0, r);

        // AND2 model, 4 vectors, SETTLE=2 -> 6 cycles per vector
        wb_wr(BASE_A + 32'h4, 32'h8);
        wb_wr(BASE_A + 32'h8, 32'h2);
        wb_wr(BASE_A + 32'h0, 32'h0002_0300);
        wb_rd(BASE_A + 32'h0, r);  check("ctrl_rb", r, 32'h0002_0300);
        wb_rd(BASE_A + 32'h8, r);  check("settle_rb", r, 32'h2);
        check("cell_sel_out", 32'(csel_a), 32'h3);
        wb_wr(BASE_A + 32'h0, 32'h0002_0301);
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            check("stim_and2", 32'(stim_a), (k == 24) ? 32'h0 : 32'((k - 1) / 6));
        end
        wb_rd(BASE_A + 32'hC, r);  check("and2_status", r, 32'h6 | IRQB);
        check("and2_irq", 32'(irq_a), 32'(IRQ_ON));

        // Interrupt clear by STATUS write 0x2
        wb_wr(BASE_A + 32'hC, 32'h2);
        check("irq_cleared", 32'(irq_a), 32'h0);
        wb_rd(BASE_A + 32'hC, r);  check("status_after_clr", r, 32'h6);

        // Fault injection: TRUTH=0xE mismatches vectors 1 and 2
        wb_wr(BASE_A + 32'h4, 32'hE);
        wb_wr(BASE_A + 32'h0, 32'h0002_0301);
        repeat (30) @(posedge clk);
        wb_rd(BASE_A + 32'hC, r);  check("fault_status", r, 32'h0002_0012 | IRQB);
        check("fault_irq", 32'(irq_a), 32'(IRQ_ON));

        // ABORT during vector 2
        wb_wr(BASE_A + 32'h4, 32'h8);
        wb_wr(BASE_A + 32'h0, 32'h0002_0301);
        check("start_clears_irq", 32'(irq_a), 32'h0);
        repeat (13) @(posedge clk);
        #1;
        check("stim_vec2", 32'(stim_a), 32'h2);
        wb_wr(BASE_A + 32'h0, 32'h0002_0302);
        check("abort_stim", 32'(stim_a), 32'h0);
        wb_rd(BASE_A + 32'hC, r);  check("abort_status", r, 32'h0);
        wb_wr(BASE_A + 32'h0, 32'h0002_0301);
        repeat (30) @(posedge clk);
        wb_rd(BASE_A + 32'hC, r);  check("rerun_status", r, 32'h6 | IRQB);

        // START with ABORT in the same write does not start
        wb_wr(BASE_A + 32'h0, 32'h0002_0303);
        repeat (3) @(posedge clk);
        #1;
        check("start_abort_stim", 32'(stim_a), 32'h0);
        wb_rd(BASE_A + 32'hC, r);  check("start_abort_busy_done", r & 32'h3, 32'h0);

        // Write protection and START while busy
        wb_wr(BASE_A + 32'h0, 32'h0002_0301);
        t0 = cyc;
        wb_rd(BASE_A + 32'hC, r);  check("busy_bit", r & 32'h1, 32'h1);
        wb_wr(BASE_A + 32'h4, 32'hFFFF);
        wb_wr(BASE_A + 32'h8, 32'h9);
        wb_wr(BASE_A + 32'h0, 32'h0004_0501);
        wb_rd(BASE_A + 32'h4, r);  check("prot_truth", r, 32'h8);
        wb_rd(BASE_A + 32'h8, r);  check("prot_settle", r, 32'h2);
        wb_rd(BASE_A + 32'h0, r);  check("prot_ctrl", r, 32'h0002_0300);
        check("prot_cell_sel", 32'(csel_a), 32'h3);
        wait_cyc(t0 + 23);
        check("no_restart_last", 32'(stim_a), 32'h3);
        wait_cyc(t0 + 24);
        check("no_restart_idle", 32'(stim_a), 32'h0);
        wb_rd(BASE_A + 32'hC, r);  check("prot_status", r, 32'h6 | IRQB);

        // NUM_IN=0 -> 2 vectors on tied-high cell, SETTLE=0 -> 4 cycles each
        wb_wr(BASE_A + 32'h4, 32'h0);
        wb_wr(BASE_A + 32'h8, 32'h0);
        wb_wr(BASE_A + 32'h0, 32'h0000_1201);
        t0 = cyc;
        wait_cyc(t0 + 7);
        check("num0_vec1", 32'(stim_a), 32'h1);
        wait_cyc(t0 + 8);
        check("num0_idle", 32'(stim_a), 32'h0);
        wb_rd(BASE_A + 32'hC, r);  check("num0_status", r, 32'h0002_0002 | IRQB);

        // NUM_IN=7 clamps to 16 vectors
        wb_wr(BASE_A + 32'h0, 32'h0007_1201);
        repeat (80) @(posedge clk);
        wb_rd(BASE_A + 32'hC, r);  check("num7_status", r, 32'h0010_0002 | IRQB);
        wb_rd(BASE_A + 32'h0, r);  check("num7_ctrl", r, 32'h0007_1200);

        // CELL_SEL beyond NCELLS samples 0, no error
        wb_wr(BASE_A + 32'h0, 32'h0002_1401);
        repeat (30) @(posedge clk);
        wb_rd(BASE_A + 32'hC, r);  check("oob_status", r, 32'h6 | IRQB);

        // ERRCNT saturation on the ERR_W=2 instance
        wb_wr(BASE_B + 32'h0, 32'h0004_0001);
        repeat (80) @(posedge clk);
        wb_rd(BASE_B + 32'hC, r);  check("sat_status", r, 32'h0003_0002 | IRQB);
        check("sat_irq", 32'(irq_b), 32'(IRQ_ON));

        // Reset in the middle of a run
        wb_wr(BASE_A + 32'h0, 32'h0002_1401);
        repeat (6) @(posedge clk);
        #1;
        check("mid_stim", 32'(stim_a), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_stim", 32'(stim_a), 32'h0);
        check("mid_rst_sel", 32'(csel_a), 32'h0);
        check("mid_rst_irq", 32'(irq_a), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wb_rd(BASE_A + 32'hC, r);  check("mid_rst_status", r, 32'h0);
        wb_rd(BASE_A + 32'h0, r);  check("mid_rst_ctrl", r, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
